// File: rtl/nco_lfo_pkg.sv
// Shared types and defaults for the LFO consumer end of the sine NCO.
package nco_lfo_pkg;

  localparam int MPR_DEF      = 26;
  localparam int APR_DEF      = 32;
  localparam int RATE_W_DEF   = 8;
  localparam int INC_STEP_DEF = 2237;
  localparam int SLEW_DEF     = 4096;
  localparam int COEF_W_DEF   = 16;
  localparam int DEPTH_W_DEF  = 8;
  localparam int WARM_MAX_DEF = 63;

  // Full-scale coefficient: unity gain, used in bypass and after reset.
  localparam logic [COEF_W_DEF-1:0] UNITY_COEF = {COEF_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WARM  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } lfo_state_e;

endpackage

// File: rtl/nco_inc_glide.sv
// Phase-increment glide: moves the NCO increment toward rate*INC_STEP by at
// most SLEW per enabled step, landing exactly on the target (no overshoot).
module nco_inc_glide
  import nco_lfo_pkg::*;
#(
  parameter int APR      = APR_DEF,
  parameter int RATE_W   = RATE_W_DEF,
  parameter int INC_STEP = INC_STEP_DEF,
  parameter int SLEW     = SLEW_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step_en,
  input  logic [RATE_W-1:0] rate_i,
  output logic [APR-1:0]    phi_inc_o
);

  localparam logic [APR-1:0] STEP_K = APR'(INC_STEP);
  localparam logic [APR-1:0] SLEW_K = APR'(SLEW);

  logic [APR-1:0] target_s;
  logic [APR-1:0] diff_s;
  logic [APR-1:0] delta_s;
  logic [APR-1:0] cur_d;
  logic [APR-1:0] cur_q;

  // Target, distance to target, slew-limited delta and the next increment.
  always_comb begin
    target_s = APR'(rate_i) * STEP_K;
    if (cur_q < target_s) begin
      diff_s = target_s - cur_q;
    end else begin
      diff_s = cur_q - target_s;
    end
    if (diff_s > SLEW_K) begin
      delta_s = SLEW_K;
    end else begin
      delta_s = diff_s;
    end
    cur_d = cur_q;
    if (step_en) begin
      if (cur_q < target_s) begin
        cur_d = cur_q + delta_s;
      end else if (cur_q > target_s) begin
        cur_d = cur_q - delta_s;
      end else begin
        cur_d = cur_q;
      end
    end else begin
      cur_d = cur_q;
    end
  end

  // Current increment register; holds whenever no step is enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q <= {APR{1'b0}};
    end else begin
      cur_q <= cur_d;
    end
  end

  assign phi_inc_o = cur_q;

endmodule

// File: rtl/nco_lfo_sink.sv
// Consumer end of the sine NCO: runs the NCO enable/warm-up FSM, glides the
// phase increment, turns the sampled sine into a depth-scaled gain
// coefficient and hands it downstream over valid/ready.
module nco_lfo_sink
  import nco_lfo_pkg::*;
#(
  parameter int MPR      = MPR_DEF,
  parameter int APR      = APR_DEF,
  parameter int RATE_W   = RATE_W_DEF,
  parameter int INC_STEP = INC_STEP_DEF,
  parameter int SLEW     = SLEW_DEF,
  parameter int COEF_W   = COEF_W_DEF,
  parameter int DEPTH_W  = DEPTH_W_DEF,
  parameter int WARM_MAX = WARM_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [RATE_W-1:0]  rate_i,
  input  logic [DEPTH_W-1:0] depth_i,
  input  logic               sample_tick,
  output logic               nco_clken,
  output logic [APR-1:0]     nco_phi_inc,
  input  logic [MPR-1:0]     nco_fsin,
  input  logic               nco_out_valid,
  output logic [COEF_W-1:0]  coef_o,
  output logic               coef_valid,
  input  logic               coef_ready,
  output logic               overrun,
  output logic               fault
);

  localparam int                    WCNT_W    = $clog2(WARM_MAX + 1);
  localparam logic [WCNT_W-1:0]     WARM_LAST = WCNT_W'(WARM_MAX - 1);
  localparam logic [COEF_W-1:0]     COEF_MAX  = {COEF_W{1'b1}};
  localparam int                    PROD_W    = COEF_W + DEPTH_W;

  lfo_state_e          state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                clken_q, clken_d;
  logic                fault_q, fault_d;
  logic                v0_q, v0_d;
  logic [COEF_W-1:0]   u_q, u_d;
  logic [COEF_W-1:0]   coef_q, coef_d;
  logic                cvalid_q, cvalid_d;
  logic                overrun_q, overrun_d;

  logic [COEF_W-1:0]   s_s;
  logic [PROD_W-1:0]   prod_s;
  logic [COEF_W-1:0]   coef_calc_s;
  logic                leave_run_s;
  logic                new_res_s;
  logic                glide_en_s;
  logic                unused_bits_s;

  // FSM next state and warm-up timeout counter.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_OFF: begin
        if (enable) begin
          state_d = ST_WARM;
          wcnt_d  = {WCNT_W{1'b0}};
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_WARM: begin
        if (!enable) begin
          state_d = ST_OFF;
        end else if (nco_out_valid) begin
          state_d = ST_RUN;
        end else if (wcnt_q == WARM_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_OFF;
        end else if (!nco_out_valid) begin
          state_d = ST_WARM;
          wcnt_d  = {WCNT_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (!enable) begin
          state_d = ST_OFF;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
    clken_d = (state_d == ST_WARM) || (state_d == ST_RUN);
    fault_d = fault_q || (state_d == ST_FAULT);
  end

  assign glide_en_s = sample_tick && ((state_q == ST_WARM) || (state_q == ST_RUN));

  nco_inc_glide #(
    .APR      (APR),
    .RATE_W   (RATE_W),
    .INC_STEP (INC_STEP),
    .SLEW     (SLEW)
  ) u_glide (
    .clk       (clk),
    .reset_n   (reset_n),
    .step_en   (glide_en_s),
    .rate_i    (rate_i),
    .phi_inc_o (nco_phi_inc)
  );

  // Coefficient pipeline: c0 captures the top sine bits as offset binary on
  // the tick; c1 (depth scaling) feeds straight into the c2 output register,
  // so coef_valid rises two cycles after the tick. Leaving RUN flushes c0 and
  // presents one unity coefficient.
  always_comb begin
    s_s         = nco_fsin[MPR-1 -: COEF_W];
    u_d         = {~s_s[COEF_W-1], s_s[COEF_W-2:0]};
    v0_d        = sample_tick && (state_q == ST_RUN) && (state_d == ST_RUN);
    prod_s      = {{COEF_W{1'b0}}, depth_i} * {{DEPTH_W{1'b0}}, u_q};
    coef_calc_s = COEF_MAX - prod_s[PROD_W-1:DEPTH_W];
    leave_run_s = (state_q == ST_RUN) && (state_d != ST_RUN);
    new_res_s   = v0_q && (state_q == ST_RUN);

    coef_d    = coef_q;
    cvalid_d  = cvalid_q;
    overrun_d = overrun_q;
    if (leave_run_s) begin
      coef_d   = COEF_MAX;
      cvalid_d = 1'b1;
    end else if (new_res_s) begin
      coef_d   = coef_calc_s;
      cvalid_d = 1'b1;
      if (cvalid_q && !coef_ready) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (cvalid_q && coef_ready) begin
      cvalid_d = 1'b0;
    end else begin
      cvalid_d = cvalid_q;
    end
  end

  // Sine bits below the coefficient width and the product fraction are dropped.
  assign unused_bits_s = ^{nco_fsin[MPR-COEF_W-1:0], prod_s[DEPTH_W-1:0]};

  // All state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_OFF;
      wcnt_q    <= {WCNT_W{1'b0}};
      clken_q   <= 1'b0;
      fault_q   <= 1'b0;
      v0_q      <= 1'b0;
      u_q       <= {COEF_W{1'b0}};
      coef_q    <= COEF_MAX;
      cvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      clken_q   <= clken_d;
      fault_q   <= fault_d;
      v0_q      <= v0_d;
      u_q       <= u_d;
      coef_q    <= coef_d;
      cvalid_q  <= cvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign nco_clken  = clken_q;
  assign coef_o     = coef_q;
  assign coef_valid = cvalid_q;
  assign overrun    = overrun_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_nco_lfo_sink.sv
// Directed, table-driven bench for nco_lfo_sink.
module tb_nco_lfo_sink;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  rate_i;
  logic [7:0]  depth_i;
  logic        sample_tick;
  logic        nco_clken;
  logic [31:0] nco_phi_inc;
  logic [25:0] nco_fsin;
  logic        nco_out_valid;
  logic [15:0] coef_o;
  logic        coef_valid;
  logic        coef_ready;
  logic        overrun;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [25:0] fsin;
    logic [7:0]  depth;
    logic [15:0] coef;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  nco_lfo_sink dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .rate_i        (rate_i),
    .depth_i       (depth_i),
    .sample_tick   (sample_tick),
    .nco_clken     (nco_clken),
    .nco_phi_inc   (nco_phi_inc),
    .nco_fsin      (nco_fsin),
    .nco_out_valid (nco_out_valid),
    .coef_o        (coef_o),
    .coef_valid    (coef_valid),
    .coef_ready    (coef_ready),
    .overrun       (overrun),
    .fault         (fault)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One tick with ready=1: nothing after one edge, result after two, accepted after three.
  task automatic run_vec(input logic [25:0] f, input logic [7:0] d, input logic [15:0] exp,
                         input string nm);
    nco_fsin    = f;
    depth_i     = d;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check({nm, "_lat1"}, {31'd0, coef_valid}, 32'd0);
    step();
    check({nm, "_valid"}, {31'd0, coef_valid}, 32'd1);
    check({nm, "_coef"}, {16'd0, coef_o}, {16'd0, exp});
    step();
    check({nm, "_accepted"}, {31'd0, coef_valid}, 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_clken"},   {31'd0, nco_clken},  32'd0);
    check({nm, "_phi"},     nco_phi_inc,         32'd0);
    check({nm, "_coef"},    {16'd0, coef_o},     32'h0000FFFF);
    check({nm, "_valid"},   {31'd0, coef_valid}, 32'd0);
    check({nm, "_overrun"}, {31'd0, overrun},    32'd0);
    check({nm, "_fault"},   {31'd0, fault},      32'd0);
  endtask

  initial begin
    logic [31:0] target;
    logic [31:0] cur_m;
    logic [31:0] prev_dut;
    logic [31:0] dut_step;
    logic [31:0] last_step;
    logic [31:0] max_step;
    logic [31:0] max_phi;
    int          hold_ticks;

    // Offset-binary / depth vectors, expected values worked by hand.
    vecs[0] = '{26'h1FFFFFF, 8'd255, 16'h0100};  // +max, full depth
    vecs[1] = '{26'h2000001, 8'd255, 16'hFFFF};  // -max, full depth
    vecs[2] = '{26'h0000000, 8'd255, 16'h807F};  // zero crossing
    vecs[3] = '{26'h1FFFFFF, 8'd0,   16'hFFFF};  // no depth
    vecs[4] = '{26'h1FFFFFF, 8'd128, 16'h8000};  // half depth
    vecs[5] = '{26'h3FFFC00, 8'd255, 16'h8080};  // just below zero
    vecs[6] = '{26'h1000000, 8'd64,  16'hCFFF};  // +half, quarter depth

    reset_n       = 1'b0;
    enable        = 1'b0;
    rate_i        = 8'd0;
    depth_i       = 8'd0;
    sample_tick   = 1'b0;
    nco_fsin      = 26'd0;
    nco_out_valid = 1'b0;
    coef_ready    = 1'b1;
    step();
    step();
    check_reset_vals("rst");
    reset_n = 1'b1;
    step();

    // 1: enable, NCO valid 20 cycles later.
    enable = 1'b1;
    step();
    check("warm_clken", {31'd0, nco_clken}, 32'd1);
    repeat (19) step();
    check("warm_clken20", {31'd0, nco_clken}, 32'd1);
    nco_out_valid = 1'b1;
    step();
    check("run_clken", {31'd0, nco_clken}, 32'd1);
    check("run_fault", {31'd0, fault}, 32'd0);

    // Frozen LFO: rate 0 from 0 stays at 0 and repeats the same coef.
    rate_i = 8'd0;
    run_vec(26'd0, 8'd255, 16'h807F, "frozen_a");
    run_vec(26'd0, 8'd255, 16'h807F, "frozen_b");
    check("frozen_phi", nco_phi_inc, 32'd0);

    // 3: coefficient table.
    foreach (vecs[i]) begin
      run_vec(vecs[i].fsin, vecs[i].depth, vecs[i].coef, $sformatf("vec%0d", i));
    end

    // 2: glide 0 -> 100*2237, one tick every 1000 clocks.
    rate_i     = 8'd100;
    target     = 32'd100 * 32'd2237;
    cur_m      = 32'd0;
    last_step  = 32'd0;
    max_step   = 32'd0;
    max_phi    = 32'd0;
    hold_ticks = 0;
    for (int k = 0; k < 80 && hold_ticks < 2; k++) begin
      prev_dut    = nco_phi_inc;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      if (cur_m < target) begin
        cur_m = cur_m + (((target - cur_m) > 32'd4096) ? 32'd4096 : (target - cur_m));
      end else begin
        hold_ticks++;
      end
      check($sformatf("glide_t%0d", k), nco_phi_inc, cur_m);
      dut_step = nco_phi_inc - prev_dut;
      if (dut_step != 32'd0) last_step = dut_step;
      if (dut_step > max_step) max_step = dut_step;
      if (nco_phi_inc > max_phi) max_phi = nco_phi_inc;
      repeat (999) step();
    end
    check("glide_final", nco_phi_inc, 32'd223700);
    check("glide_last_step", last_step, 32'd2516);
    check("glide_step_le_slew", {31'd0, (max_step > 32'd4096)}, 32'd0);
    check("glide_no_overshoot", {31'd0, (max_phi > 32'd223700)}, 32'd0);

    // 4: ready low across two results.
    coef_ready  = 1'b0;
    nco_fsin    = 26'h2000001;
    depth_i     = 8'd255;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    check("ovr_first_valid", {31'd0, coef_valid}, 32'd1);
    check("ovr_first_coef", {16'd0, coef_o}, 32'h0000FFFF);
    check("ovr_first_flag", {31'd0, overrun}, 32'd0);
    repeat (3) step();
    check("ovr_hold_valid", {31'd0, coef_valid}, 32'd1);
    nco_fsin    = 26'h1FFFFFF;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("ovr_hold_coef", {16'd0, coef_o}, 32'h0000FFFF);
    step();
    check("ovr_second_coef", {16'd0, coef_o}, 32'h00000100);
    check("ovr_second_valid", {31'd0, coef_valid}, 32'd1);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    repeat (2) step();
    check("ovr_stable_coef", {16'd0, coef_o}, 32'h00000100);
    check("ovr_stable_valid", {31'd0, coef_valid}, 32'd1);
    coef_ready = 1'b1;
    step();
    check("ovr_accept", {31'd0, coef_valid}, 32'd0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Bypass: leaving RUN presents one unity coefficient.
    coef_ready = 1'b0;
    enable     = 1'b0;
    step();
    check("byp_clken", {31'd0, nco_clken}, 32'd0);
    check("byp_valid", {31'd0, coef_valid}, 32'd1);
    check("byp_coef", {16'd0, coef_o}, 32'h0000FFFF);
    step();
    check("byp_hold", {31'd0, coef_valid}, 32'd1);
    coef_ready = 1'b1;
    step();
    check("byp_accept", {31'd0, coef_valid}, 32'd0);
    rate_i      = 8'd0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    check("off_tick_nocoef", {31'd0, coef_valid}, 32'd0);
    check("off_phi_hold", nco_phi_inc, 32'd223700);

    // 5: NCO never valid -> fault after 63 warm cycles.
    nco_out_valid = 1'b0;
    enable        = 1'b1;
    repeat (63) step();
    check("fault_not_early", {31'd0, fault}, 32'd0);
    check("fault_warm_clken", {31'd0, nco_clken}, 32'd1);
    step();
    check("fault_set", {31'd0, fault}, 32'd1);
    check("fault_clken", {31'd0, nco_clken}, 32'd0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    check("fault_tick_nocoef", {31'd0, coef_valid}, 32'd0);
    check("fault_phi_hold", nco_phi_inc, 32'd223700);
    enable = 1'b0;
    step();
    check("fault_off_sticky", {31'd0, fault}, 32'd1);
    check("fault_off_clken", {31'd0, nco_clken}, 32'd0);

    // 6: async reset mid-RUN with a pending coefficient.
    reset_n = 1'b0;
    step();
    reset_n       = 1'b1;
    enable        = 1'b1;
    nco_out_valid = 1'b1;
    rate_i        = 8'd100;
    step();
    step();
    coef_ready  = 1'b0;
    nco_fsin    = 26'h1FFFFFF;
    depth_i     = 8'd255;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    check("rst6_pre_valid", {31'd0, coef_valid}, 32'd1);
    check("rst6_pre_coef", {16'd0, coef_o}, 32'h00000100);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst6");
    step();
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
